// File: rtl/dart_board_scorer_if.sv
// Load/throw/result bus of the dartboard scorer: the pattern generator drives
// score words and darts, the scorer returns a one-cycle result pulse.
interface dart_board_scorer_if #(
  parameter int SECTORS = 8,
  parameter int RINGS   = 2,
  parameter int SCORE_W = 3,
  parameter int SUM_W   = 7,
  parameter int CNT_W   = 6
);
  localparam int SW = $clog2(SECTORS);
  localparam int RW = (RINGS > 2) ? $clog2(RINGS) : 1;

  logic               in_valid_1;
  logic [SCORE_W-1:0] in_score;
  logic               in_valid_2;
  logic [RW+SW-1:0]   in_dart;
  logic [RW-1:0]      in_rot_sel;
  logic [SW-1:0]      in_rotation;
  logic               rotate_flag;
  logic               out_valid;
  logic [SUM_W-1:0]   out_sum;
  logic [CNT_W-1:0]   out_darts;

  modport master (
    output in_valid_1, in_score, in_valid_2, in_dart, in_rot_sel, in_rotation, rotate_flag,
    input  out_valid, out_sum, out_darts
  );

  modport slave (
    input  in_valid_1, in_score, in_valid_2, in_dart, in_rot_sel, in_rotation, rotate_flag,
    output out_valid, out_sum, out_darts
  );
endinterface

// File: rtl/dart_board_scorer.sv
// Multi-ring dartboard scorer: serial board load, contiguous dart burst scored
// against rotating/swapping ring slots, saturated total reported as a pulse.
module dart_board_scorer #(
  parameter int SECTORS = 8,
  parameter int RINGS   = 2,
  parameter int SCORE_W = 3,
  parameter int SUM_W   = 7,
  parameter int CNT_W   = 6
) (
  input logic               clk,
  input logic               rst_n,
  dart_board_scorer_if.slave bus
);
  localparam int SW    = $clog2(SECTORS);
  localparam int RW    = (RINGS > 2) ? $clog2(RINGS) : 1;
  localparam int RW1   = RW + 1;
  localparam int LW    = RW + SW;
  localparam int TOTAL = RINGS * SECTORS;
  localparam int ACC_W = SUM_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, THROW, DONE, OUT} state_t;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [SCORE_W-1:0] b);
    logic [ACC_W-1:0] t;
    t = ACC_W'(a) + ACC_W'(b);
    return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic               load_en, dart_en, game_init;
  logic [LW-1:0]      load_cnt_q, wr_addr;
  logic [SCORE_W-1:0] board [TOTAL];

  logic [RW-1:0]      slot_p [RINGS];
  logic [SW-1:0]      slot_o [RINGS];

  logic               vld_p0;
  logic [LW-1:0]      dart_p0;
  logic [RW-1:0]      rot_sel_p0;
  logic [SW-1:0]      rotation_p0;
  logic               ccw_p0;

  logic [SUM_W-1:0]   sum_p1;
  logic [CNT_W-1:0]   cnt_p1;

  logic               res_vld_p2;
  logic [SUM_W-1:0]   res_sum_p2;
  logic [CNT_W-1:0]   res_cnt_p2;

  logic [RW-1:0]      ring_p0, ring_idx, sel_idx, partner;
  logic [SW-1:0]      sec_p0, lane;
  logic [LW-1:0]      rd_addr;
  logic               ring_ok, sel_ok;
  logic [SCORE_W-1:0] score;

  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    dart_en   = 1'b0;
    game_init = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid_1) begin
        load_en   = 1'b1;
        game_init = 1'b1;
        state_d   = LOAD;
      end
      LOAD: if (bus.in_valid_1) begin
        load_en = 1'b1;
        if (load_cnt_q == LW'(TOTAL - 1)) state_d = WAIT;
      end
      WAIT: if (bus.in_valid_2) begin
        dart_en = 1'b1;
        state_d = THROW;
      end
      THROW: begin
        if (bus.in_valid_2) dart_en = 1'b1;
        else                state_d = DONE;
      end
      DONE:    state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The first word is taken in IDLE, so the load address restarts at zero there.
  assign wr_addr = game_init ? '0 : load_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q <= '0;
      for (int i = 0; i < TOTAL; i++) board[i] <= '0;
    end else if (load_en) begin
      load_cnt_q     <= wr_addr + 1'b1;
      board[wr_addr] <= bus.in_score;
    end
  end

  // ---- stage 0: dart capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= dart_en;
  end

  always_ff @(posedge clk) begin
    if (dart_en) begin
      dart_p0     <= bus.in_dart;
      rot_sel_p0  <= bus.in_rot_sel;
      rotation_p0 <= bus.in_rotation;
      ccw_p0      <= bus.rotate_flag;
    end
  end

  // ---- stage 1: score lookup, accumulate, reorient ----
  always_comb begin
    ring_p0  = dart_p0[LW-1:SW];
    sec_p0   = dart_p0[SW-1:0];
    ring_ok  = {1'b0, ring_p0} < RW1'(RINGS);
    ring_idx = ring_ok ? ring_p0 : '0;
    lane     = slot_o[ring_idx] + sec_p0;
    rd_addr  = {slot_p[ring_idx], lane};
    score    = ring_ok ? board[rd_addr] : '0;
    sel_ok   = {1'b0, rot_sel_p0} < RW1'(RINGS);
    sel_idx  = sel_ok ? rot_sel_p0 : '0;
    partner  = (sel_idx == RW'(RINGS - 1)) ? '0 : sel_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1 <= '0;
      cnt_p1 <= '0;
      for (int r = 0; r < RINGS; r++) begin
        slot_p[r] <= RW'(r);
        slot_o[r] <= '0;
      end
    end else if (game_init) begin
      sum_p1 <= '0;
      cnt_p1 <= '0;
      for (int r = 0; r < RINGS; r++) begin
        slot_p[r] <= RW'(r);
        slot_o[r] <= '0;
      end
    end else if (vld_p0) begin
      sum_p1 <= sat_add(sum_p1, score);
      cnt_p1 <= sat_inc(cnt_p1);
      if (sel_ok) begin
        if (rotation_p0 != '0) begin
          slot_o[sel_idx] <= ccw_p0 ? slot_o[sel_idx] + rotation_p0
                                    : slot_o[sel_idx] - rotation_p0;
        end else begin
          slot_p[sel_idx] <= slot_p[partner];
          slot_o[sel_idx] <= slot_o[partner];
          slot_p[partner] <= slot_p[sel_idx];
          slot_o[partner] <= slot_o[sel_idx];
        end
      end
    end
  end

  // ---- stage 2: result register, live only in the OUT cycle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld_p2 <= 1'b0;
      res_sum_p2 <= '0;
      res_cnt_p2 <= '0;
    end else begin
      res_vld_p2 <= (state_q == DONE);
      res_sum_p2 <= (state_q == DONE) ? sum_p1 : '0;
      res_cnt_p2 <= (state_q == DONE) ? cnt_p1 : '0;
    end
  end

  assign bus.out_valid = res_vld_p2;
  assign bus.out_sum   = res_sum_p2;
  assign bus.out_darts = res_cnt_p2;
endmodule

// File: tb/tb_dart_board_scorer.sv
// Directed bench for dart_board_scorer: table of games on the default board,
// plus hand-written reset-abort and three-ring (invalid ring / wrap swap) games.
module tb_dart_board_scorer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dart_board_scorer_if bus ();
  dart_board_scorer_if #(.RINGS(3)) bus3 ();

  dart_board_scorer u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  dart_board_scorer #(.RINGS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  typedef struct {
    int ring, sec, sel, step, ccw;
  } dart_t;

  typedef struct {
    string name;
    int first, n, exp_sum, exp_darts, gaps, wait_junk;
  } game_t;

  dart_t darts[$];
  game_t games[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int word_of(input int k);
    if (k < 8)  return k;
    if (k < 16) return 15 - k;
    return 1;
  endfunction

  task automatic add_dart(input int r, input int s, input int sel, input int st, input int ccw);
    dart_t d;
    d.ring = r; d.sec = s; d.sel = sel; d.step = st; d.ccw = ccw;
    darts.push_back(d);
  endtask

  task automatic add_game(input string name, input int n, input int es, input int ed,
                          input int gaps, input int junk);
    game_t g;
    g.name = name; g.first = darts.size() - n; g.n = n;
    g.exp_sum = es; g.exp_darts = ed; g.gaps = gaps; g.wait_junk = junk;
    games.push_back(g);
  endtask

  // Gapped load: 5 idle gaps carrying in_valid_2, plus in_valid_2 in IDLE and on a live word.
  task automatic load_board(input int gaps);
    int ngap;
    ngap = 0;
    if (gaps != 0) begin
      bus.in_valid_2 = 1'b1; bus.in_dart = 4'd3;
      step();
    end
    for (int k = 0; k < 16; k++) begin
      if (gaps != 0 && k % 3 == 1 && ngap < 5) begin
        bus.in_valid_1 = 1'b0; bus.in_valid_2 = 1'b1; bus.in_dart = 4'(k);
        ngap++;
        step();
      end
      bus.in_valid_1 = 1'b1;
      bus.in_score   = 3'(word_of(k));
      bus.in_valid_2 = (gaps != 0 && k == 6);
      step();
    end
    bus.in_valid_1 = 1'b0;
    bus.in_valid_2 = 1'b0;
  endtask

  task automatic throw_dart(input dart_t d);
    bus.in_valid_2  = 1'b1;
    bus.in_dart     = 4'(d.ring * 8 + d.sec);
    bus.in_rot_sel  = 1'(d.sel);
    bus.in_rotation = 3'(d.step);
    bus.rotate_flag = 1'(d.ccw);
    step();
  endtask

  // Called in cycle L+1; result must appear in L+3 only. in_valid_2 is
  // re-asserted in L+2/L+3 and must be ignored.
  task automatic finish_game(input string name, input int es, input int ed);
    bus.in_valid_2 = 1'b0;
    check({name, ".vld_L1"}, int'(bus.out_valid), 0);
    step();
    bus.in_valid_2 = 1'b1; bus.in_dart = 4'd1;
    check({name, ".vld_L2"}, int'(bus.out_valid), 0);
    step();
    check({name, ".vld_L3"}, int'(bus.out_valid), 1);
    check({name, ".sum"},    int'(bus.out_sum), es);
    check({name, ".darts"},  int'(bus.out_darts), ed);
    step();
    bus.in_valid_2 = 1'b0;
    check({name, ".vld_L4"}, int'(bus.out_valid), 0);
    check({name, ".sum_L4"}, int'(bus.out_sum), 0);
    step();
    step();
    check({name, ".no_extra"}, int'(bus.out_valid), 0);
  endtask

  task automatic play(input game_t g);
    load_board(g.gaps);
    if (g.wait_junk != 0) begin
      bus.in_valid_1 = 1'b1; bus.in_score = 3'd5;
      step();
      bus.in_valid_1 = 1'b0;
    end
    for (int i = 0; i < g.n; i++) throw_dart(darts[g.first + i]);
    finish_game(g.name, g.exp_sum, g.exp_darts);
  endtask

  task automatic throw3(input int r, input int s, input int sel, input int st, input int ccw);
    bus3.in_valid_2  = 1'b1;
    bus3.in_dart     = 5'(r * 8 + s);
    bus3.in_rot_sel  = 2'(sel);
    bus3.in_rotation = 3'(st);
    bus3.rotate_flag = 1'(ccw);
    step();
  endtask

  initial begin
    bus.in_valid_1 = 1'b0; bus.in_score = '0; bus.in_valid_2 = 1'b0; bus.in_dart = '0;
    bus.in_rot_sel = '0; bus.in_rotation = '0; bus.rotate_flag = 1'b0;
    bus3.in_valid_1 = 1'b0; bus3.in_score = '0; bus3.in_valid_2 = 1'b0; bus3.in_dart = '0;
    bus3.in_rot_sel = '0; bus3.in_rotation = '0; bus3.rotate_flag = 1'b0;

    add_dart(0, 3, 0, 1, 1); add_dart(0, 3, 0, 1, 1);
    add_game("rotate", 2, 7, 2, 0, 0);
    add_dart(0, 0, 0, 2, 1); add_dart(0, 0, 0, 0, 0);
    add_dart(1, 1, 1, 1, 0); add_dart(0, 1, 0, 1, 0);
    add_game("swap", 4, 11, 4, 0, 1);
    add_dart(0, 0, 0, 3, 0); add_dart(0, 0, 0, 1, 1);
    add_game("cw_wrap", 2, 5, 2, 0, 0);
    for (int i = 0; i < 20; i++) add_dart(1, 0, 0, 1, 1);
    add_game("sum_sat", 20, 127, 20, 0, 0);
    for (int i = 0; i < 70; i++) add_dart(0, 0, 0, 1, 1);
    add_game("cnt_sat", 70, 127, 63, 0, 0);
    add_dart(0, 3, 0, 1, 1); add_dart(0, 3, 0, 1, 1);
    add_game("load_gaps", 2, 7, 2, 1, 0);

    repeat (3) step();
    check("reset.vld",   int'(bus.out_valid), 0);
    check("reset.sum",   int'(bus.out_sum), 0);
    check("reset.darts", int'(bus.out_darts), 0);
    rst_n = 1'b1;
    step();

    foreach (games[g]) play(games[g]);

    // Abort after two darts: no result may ever appear for that game.
    begin
      int seen;
      seen = 0;
      load_board(0);
      throw_dart(darts[0]);
      throw_dart(darts[1]);
      bus.in_valid_2 = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort.vld",   int'(bus.out_valid), 0);
      check("abort.sum",   int'(bus.out_sum), 0);
      check("abort.darts", int'(bus.out_darts), 0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (bus.out_valid) seen++;
        step();
      end
      check("abort.no_pulse", seen, 0);
    end
    play(games[0]);

    // Three rings: invalid ring 3 scores 0, sel 3 does nothing, swap of slot 2 wraps to slot 0.
    for (int k = 0; k < 24; k++) begin
      bus3.in_valid_1 = 1'b1;
      bus3.in_score   = 3'(word_of(k));
      step();
    end
    bus3.in_valid_1 = 1'b0;
    throw3(3, 0, 3, 0, 0);
    throw3(2, 5, 2, 0, 0);
    throw3(0, 0, 0, 1, 1);
    throw3(2, 3, 1, 0, 0);
    bus3.in_valid_2 = 1'b0;
    check("r3.vld_L1", int'(bus3.out_valid), 0);
    step();
    check("r3.vld_L2", int'(bus3.out_valid), 0);
    step();
    check("r3.vld_L3", int'(bus3.out_valid), 1);
    check("r3.sum",    int'(bus3.out_sum), 5);
    check("r3.darts",  int'(bus3.out_darts), 4);
    step();
    check("r3.vld_L4", int'(bus3.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
